// File: rtl/tpu_host_driver_pkg.sv
// tpu_host_pkg: shared types for the tpu_core host driver.
//   cmd_op_e     - host command opcodes (LOAD_INSTR, WRITE, READ, COMPUTE)
//   MODE_*       - tpu_core mode encodings driven on tpu_mode
//   drv_state_e  - driver FSM states
//   op_to_mode() - core mode that starts a given command
package tpu_host_pkg;

  typedef enum logic [1:0] {
    OP_LOAD    = 2'd0,
    OP_WRITE   = 2'd1,
    OP_READ    = 2'd2,
    OP_COMPUTE = 2'd3
  } cmd_op_e;

  localparam logic [2:0] MODE_IDLE    = 3'd0;
  localparam logic [2:0] MODE_WRITE   = 3'd1;
  localparam logic [2:0] MODE_READ    = 3'd2;
  localparam logic [2:0] MODE_COMPUTE = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_XFER_W = 3'd3,
    ST_XFER_R = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_RESP   = 3'd6
  } drv_state_e;

  function automatic logic [2:0] op_to_mode(input cmd_op_e op);
    logic [2:0] mode;
    case (op)
      OP_WRITE:   mode = MODE_WRITE;
      OP_READ:    mode = MODE_READ;
      OP_COMPUTE: mode = MODE_COMPUTE;
      default:    mode = MODE_IDLE;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/tpu_host_driver_if.sv
// tpu_host_driver_if: direct-control bus between the host driver and tpu_core.
//   tpu_mode/base_addr/dma_len  - command setup, driver -> core
//   busy/done                   - core status, core -> driver
//   din_*                       - write-data stream, driver -> core
//   dout_*                      - read-data stream, core -> driver
//   instr_*                     - instruction write port, driver -> core
// modport master = driver side, modport slave = core side.
interface tpu_host_driver_if;
  logic [2:0]  tpu_mode;
  logic [12:0] base_addr;
  logic [31:0] dma_len;
  logic        busy;
  logic        done;
  logic        din_valid;
  logic        din_ready;
  logic [63:0] din_data;
  logic        dout_valid;
  logic        dout_ready;
  logic [31:0] dout_data;
  logic        instr_valid;
  logic [63:0] instr_data;
  logic [7:0]  instr_addr;

  modport master (
    output tpu_mode, base_addr, dma_len, din_valid, din_data, dout_ready,
           instr_valid, instr_data, instr_addr,
    input  busy, done, din_ready, dout_valid, dout_data
  );

  modport slave (
    input  tpu_mode, base_addr, dma_len, din_valid, din_data, dout_ready,
           instr_valid, instr_data, instr_addr,
    output busy, done, din_ready, dout_valid, dout_data
  );
endinterface

// File: rtl/tpu_host_driver.sv
// tpu_host_driver: host-side initiator for tpu_core direct control.
// Accepts one command (LOAD_INSTR/WRITE/READ/COMPUTE), sequences the core
// mode handshake, streams data between host streams and the core, and
// returns a completion response.
// Ports:
//   clk, rst_n                  - clock, synchronous active-low reset
//   cmd_*                       - command descriptor handshake
//   wdata_*                     - host write-data stream (into driver)
//   rdata_*                     - host read-data stream (out of driver)
//   rsp_*                       - completion response (err, beats)
//   core                        - tpu_host_driver_if master to tpu_core
module tpu_host_driver
  import tpu_host_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 100000,
  parameter int TO_W    = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [12:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wdata_valid,
  output logic             wdata_ready,
  input  logic [63:0]      wdata,
  output logic             rdata_valid,
  input  logic             rdata_ready,
  output logic [31:0]      rdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_err,
  output logic [LEN_W-1:0] rsp_beats,
  tpu_host_driver_if.master core
);

  drv_state_e       state_r, state_s;
  cmd_op_e          op_r;
  logic [12:0]      addr_r;
  logic [LEN_W-1:0] len_r, cnt_r, rsp_beats_r;
  logic [TO_W-1:0]  to_cnt_r;
  logic [2:0]       mode_r;
  logic             rsp_err_r, instr_valid_r;
  logic [63:0]      instr_data_r;
  logic [7:0]       instr_addr_r;
  logic             beat_s, last_s, to_hit_s, zero_len_s, load_ovf_s;
  logic             din_valid_s, dout_ready_s;
  logic [LEN_W:0]   load_end_s;

  // A zero-length LOAD/WRITE/READ would underflow the core's dma_len-1 count.
  assign zero_len_s = (cmd_len == {LEN_W{1'b0}}) && (cmd_op_e'(cmd_op) != OP_COMPUTE);
  // LOAD must stay inside the 256-entry instruction memory.
  assign load_end_s = {{(LEN_W-7){1'b0}}, cmd_addr[7:0]} + {1'b0, cmd_len};
  assign load_ovf_s = (cmd_op_e'(cmd_op) == OP_LOAD) && (load_end_s > (LEN_W+1)'(256));
  assign last_s     = (cnt_r + LEN_W'(1)) == len_r;
  assign to_hit_s   = to_cnt_r == TO_W'(TIMEOUT - 1);

  // Next-state logic and combinational stream routing.
  always_comb begin
    state_s      = state_r;
    cmd_ready    = 1'b0;
    wdata_ready  = 1'b0;
    rdata_valid  = 1'b0;
    din_valid_s  = 1'b0;
    dout_ready_s = 1'b0;
    beat_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (!cmd_valid) state_s = ST_IDLE;
        else if (zero_len_s || load_ovf_s) state_s = ST_RESP;
        else if (cmd_op_e'(cmd_op) == OP_LOAD) state_s = ST_LOAD;
        else state_s = ST_ISSUE;
      end
      ST_LOAD: begin
        wdata_ready = 1'b1;
        beat_s      = wdata_valid;
        if (beat_s && last_s) state_s = ST_RESP;
        else state_s = ST_LOAD;
      end
      ST_ISSUE: begin
        if (core.busy) begin
          case (op_r)
            OP_WRITE: state_s = ST_XFER_W;
            OP_READ:  state_s = ST_XFER_R;
            default:  state_s = ST_DRAIN;
          endcase
        end else if (to_hit_s) state_s = ST_RESP;
        else state_s = ST_ISSUE;
      end
      ST_XFER_W: begin
        din_valid_s = wdata_valid;
        wdata_ready = core.din_ready;
        beat_s      = wdata_valid && core.din_ready;
        if (beat_s && last_s) state_s = ST_DRAIN;
        else if (to_hit_s) state_s = ST_RESP;
        else state_s = ST_XFER_W;
      end
      ST_XFER_R: begin
        rdata_valid  = core.dout_valid;
        dout_ready_s = rdata_ready;
        beat_s       = core.dout_valid && rdata_ready;
        if (beat_s && last_s) state_s = ST_DRAIN;
        else if (to_hit_s) state_s = ST_RESP;
        else state_s = ST_XFER_R;
      end
      ST_DRAIN: begin
        if (core.done || to_hit_s) state_s = ST_RESP;
        else state_s = ST_DRAIN;
      end
      ST_RESP: begin
        if (rsp_ready) state_s = ST_IDLE;
        else state_s = ST_RESP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Command registers, beat/timeout counters, core mode and response fields.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_r          <= OP_LOAD;
      addr_r        <= 13'd0;
      len_r         <= {LEN_W{1'b0}};
      cnt_r         <= {LEN_W{1'b0}};
      to_cnt_r      <= {TO_W{1'b0}};
      mode_r        <= MODE_IDLE;
      rsp_err_r     <= 1'b0;
      rsp_beats_r   <= {LEN_W{1'b0}};
      instr_valid_r <= 1'b0;
      instr_data_r  <= 64'd0;
      instr_addr_r  <= 8'd0;
    end else begin
      instr_valid_r <= 1'b0;
      if (state_s != state_r) to_cnt_r <= {TO_W{1'b0}};
      else if (state_r inside {ST_ISSUE, ST_XFER_W, ST_XFER_R, ST_DRAIN})
        to_cnt_r <= to_cnt_r + TO_W'(1);
      if (beat_s) cnt_r <= cnt_r + LEN_W'(1);
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_r   <= cmd_op_e'(cmd_op);
            addr_r <= cmd_addr;
            len_r  <= cmd_len;
            cnt_r  <= {LEN_W{1'b0}};
            if (state_s == ST_ISSUE) mode_r <= op_to_mode(cmd_op_e'(cmd_op));
            if (state_s == ST_RESP) begin
              rsp_err_r   <= load_ovf_s;
              rsp_beats_r <= {LEN_W{1'b0}};
            end
          end
        end
        ST_LOAD: begin
          if (beat_s) begin
            instr_valid_r <= 1'b1;
            instr_data_r  <= wdata;
            instr_addr_r  <= addr_r[7:0] + cnt_r[7:0];
          end
          if (state_s == ST_RESP) begin
            rsp_err_r   <= 1'b0;
            rsp_beats_r <= len_r;
          end
        end
        ST_ISSUE, ST_XFER_W, ST_XFER_R: begin
          // The core ignores mode once executing, so drop it as soon as busy is seen.
          if (state_s != ST_ISSUE) mode_r <= MODE_IDLE;
          if (state_s == ST_RESP) begin
            rsp_err_r   <= 1'b1;
            rsp_beats_r <= cnt_r + {{(LEN_W-1){1'b0}}, beat_s};
          end
        end
        ST_DRAIN: begin
          mode_r <= MODE_IDLE;
          if (state_s == ST_RESP) begin
            rsp_err_r   <= !core.done;
            rsp_beats_r <= cnt_r;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rsp_valid        = (state_r == ST_RESP);
  assign rsp_err          = rsp_err_r;
  assign rsp_beats        = rsp_beats_r;
  assign rdata            = core.dout_data;
  assign core.tpu_mode    = mode_r;
  assign core.base_addr   = addr_r;
  assign core.dma_len     = {{(32-LEN_W){1'b0}}, len_r};
  assign core.din_valid   = din_valid_s;
  assign core.din_data    = wdata;
  assign core.dout_ready  = dout_ready_s;
  assign core.instr_valid = instr_valid_r;
  assign core.instr_data  = instr_data_r;
  assign core.instr_addr  = instr_addr_r;

endmodule

// File: tb/tb_tpu_host_driver.sv
// Self-checking bench for tpu_host_driver: directed vector table, randomized
// commands against a transaction-level reference model, plus timeout and
// mid-transfer reset sequences. A behavioural tpu_core model answers the bus.
module tb_tpu_host_driver;
  localparam int LEN_W      = 16;
  localparam int TB_TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [12:0] cmd_addr;
  logic [15:0] cmd_len;
  logic wdata_valid, wdata_ready;
  logic [63:0] wdata;
  logic rdata_valid, rdata_ready;
  logic [31:0] rdata;
  logic rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_beats;

  tpu_host_driver_if core_bus();

  tpu_host_driver #(.LEN_W(LEN_W), .TIMEOUT(TB_TIMEOUT), .TO_W(17)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
    .rsp_beats(rsp_beats), .core(core_bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---- environment state (host + core model) ----
  bit rst_req = 1'b1, cmd_go = 1'b0, core_stall = 1'b0, dout_stuck = 1'b0;
  logic [1:0] c_op = 2'd0;
  logic [12:0] c_addr = 13'd0;
  logic [15:0] c_len = 16'd0;
  int pat = 0, comp_delay = 1, cyc = 0;
  logic [63:0] wq[$], wsrc[$];
  logic [31:0] rq_core[$], csrc[$];
  logic [31:0] got_din[$], got_rd[$], exp_din[$], exp_rd[$];
  logic [71:0] got_instr[$], exp_instr[$];
  int c_phase = 0, c_left = 0, c_wait = 0;
  bit c_done = 1'b0, busy_prev = 1'b0;
  bit rsp_got = 1'b0;
  logic rsp_err_got;
  logic [15:0] rsp_beats_got;
  int done_cnt, first_mode, mode_bad, mirror_bad, acc_cyc, rsp_cyc;
  int exp_done, exp_mode;
  logic exp_err;
  logic [15:0] exp_beats;

  function automatic bit pbit();
    case (pat)
      0:       return (cyc % 2) == 1;
      1:       return $urandom_range(3, 0) != 0;
      default: return 1'b1;
    endcase
  endfunction

  // Drive all DUT inputs on the falling edge; observe 1 time unit before the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      rst_n       = !rst_req;
      cmd_valid   = cmd_go;
      cmd_op      = c_op;
      cmd_addr    = c_addr;
      cmd_len     = c_len;
      wdata_valid = (wq.size() > 0) && pbit();
      wdata       = (wq.size() > 0) ? wq[0] : 64'd0;
      rdata_ready = pbit();
      rsp_ready   = pbit();
      core_bus.busy       = (c_phase != 0);
      core_bus.done       = c_done;
      core_bus.din_ready  = (c_phase == 1) && !core_stall && pbit();
      core_bus.dout_valid = (c_phase == 2) && !dout_stuck && (c_left > 0) && pbit();
      core_bus.dout_data  = (rq_core.size() > 0) ? rq_core[0] : 32'd0;
      #4;
      if (!rst_n) begin
        c_phase = 0; c_done = 1'b0; busy_prev = 1'b0;
      end else begin
        if (cmd_valid && cmd_ready) begin cmd_go = 1'b0; acc_cyc = cyc; end
        if (wdata_valid && wdata_ready) void'(wq.pop_front());
        if (rdata_valid && rdata_ready) got_rd.push_back(rdata);
        if (core_bus.dout_ready && !rdata_ready) mirror_bad++;
        if (rdata_valid && (!core_bus.dout_valid || rdata !== core_bus.dout_data)) mirror_bad++;
        if (core_bus.din_valid && (!wdata_valid || core_bus.din_data !== wdata)) mirror_bad++;
        if (core_bus.din_valid && core_bus.din_ready) begin
          got_din.push_back(core_bus.din_data[31:0]); c_left--;
        end
        if (core_bus.dout_valid && core_bus.dout_ready) begin
          void'(rq_core.pop_front()); c_left--;
        end
        if (core_bus.instr_valid) got_instr.push_back({core_bus.instr_addr, core_bus.instr_data});
        if (rsp_valid && rsp_cyc < 0) rsp_cyc = cyc;
        if (rsp_valid && rsp_ready && !rsp_got) begin
          rsp_got = 1'b1; rsp_err_got = rsp_err; rsp_beats_got = rsp_beats;
        end
        if (core_bus.done) done_cnt++;
        if (core_bus.tpu_mode != 3'd0 && first_mode == 0) first_mode = int'(core_bus.tpu_mode);
        if (busy_prev && core_bus.tpu_mode != 3'd0) mode_bad++;
        busy_prev = core_bus.busy;
        // core model: start on a nonzero mode, finish with a one-cycle done
        c_done = 1'b0;
        if (c_phase == 0) begin
          if (core_bus.tpu_mode != 3'd0 && !core_bus.done) begin
            c_phase = int'(core_bus.tpu_mode); c_left = int'(core_bus.dma_len); c_wait = 0;
          end
        end else if (c_phase == 3) begin
          c_wait++;
          if (c_wait >= comp_delay) begin c_done = 1'b1; c_phase = 0; end
        end else if (c_left <= 0) begin
          c_done = 1'b1; c_phase = 0;
        end
      end
    end
  end

  // Prepare host/core data for a command and post it to the driver.
  task automatic start_cmd(input logic [1:0] op, input logic [12:0] addr, input logic [15:0] len);
    @(posedge clk);
    wsrc.delete(); csrc.delete(); wq.delete(); rq_core.delete();
    got_din.delete(); got_rd.delete(); got_instr.delete();
    for (int i = 0; i < int'(len); i++) begin
      wsrc.push_back({$urandom, 32'hA + 32'(i)});
      csrc.push_back((pat == 0) ? 32'h11 * 32'(i + 1) : $urandom);
    end
    if (op == 2'd0 || op == 2'd1) wq = wsrc;
    if (op == 2'd2) rq_core = csrc;
    done_cnt = 0; first_mode = 0; mode_bad = 0; mirror_bad = 0;
    acc_cyc = -1; rsp_cyc = -1; rsp_got = 1'b0;
    c_op = op; c_addr = addr; c_len = len; cmd_go = 1'b1;
  endtask

  task automatic wait_rsp(input string tag);
    for (int i = 0; i < 4000 && !rsp_got; i++) @(posedge clk);
    chk({tag, ".rsp_handshake"}, 64'(rsp_got), 64'd1);
  endtask

  // Transaction-level reference: what the command should produce.
  task automatic model(input logic [1:0] op, input logic [12:0] addr, input logic [15:0] len);
    exp_din.delete(); exp_rd.delete(); exp_instr.delete();
    exp_err = 1'b0; exp_beats = 16'd0; exp_done = 0; exp_mode = 0;
    if (op != 2'd3 && len == 16'd0) begin
    end else if (op == 2'd0) begin
      if (int'(addr[7:0]) + int'(len) > 256) exp_err = 1'b1;
      else begin
        exp_beats = len;
        for (int i = 0; i < int'(len); i++)
          exp_instr.push_back({8'((int'(addr[7:0]) + i) % 256), wsrc[i]});
      end
    end else begin
      exp_mode = int'(op); exp_done = 1;
      exp_beats = (op == 2'd3) ? 16'd0 : len;
      for (int i = 0; i < int'(len); i++) begin
        if (op == 2'd1) exp_din.push_back(wsrc[i][31:0]);
        if (op == 2'd2) exp_rd.push_back(csrc[i]);
      end
    end
  endtask

  task automatic compare(input string tag);
    int bad;
    chk({tag, ".err"}, 64'(rsp_err_got), 64'(exp_err));
    chk({tag, ".beats"}, 64'(rsp_beats_got), 64'(exp_beats));
    chk({tag, ".done_count"}, 64'(done_cnt), 64'(exp_done));
    chk({tag, ".first_mode"}, 64'(first_mode), 64'(exp_mode));
    chk({tag, ".mode_after_busy"}, 64'(mode_bad), 64'd0);
    chk({tag, ".stream_mirror"}, 64'(mirror_bad), 64'd0);
    chk({tag, ".din_count"}, 64'(got_din.size()), 64'(exp_din.size()));
    chk({tag, ".rdata_count"}, 64'(got_rd.size()), 64'(exp_rd.size()));
    chk({tag, ".instr_count"}, 64'(got_instr.size()), 64'(exp_instr.size()));
    bad = 0;
    for (int i = 0; i < got_din.size() && i < exp_din.size(); i++) if (got_din[i] !== exp_din[i]) bad++;
    for (int i = 0; i < got_rd.size() && i < exp_rd.size(); i++) if (got_rd[i] !== exp_rd[i]) bad++;
    for (int i = 0; i < got_instr.size() && i < exp_instr.size(); i++) if (got_instr[i] !== exp_instr[i]) bad++;
    chk({tag, ".data_order"}, 64'(bad), 64'd0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [12:0] addr;
    logic [15:0] len;
    int          cdelay;
    logic        err;
    logic [15:0] beats;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // directed vectors: {op, addr, len, compute delay, expected err, expected beats}
    vecs.push_back('{2'd1, 13'h010, 16'd4,   1,  1'b0, 16'd4});
    vecs.push_back('{2'd2, 13'h020, 16'd3,   1,  1'b0, 16'd3});
    vecs.push_back('{2'd0, 13'h0FE, 16'd2,   1,  1'b0, 16'd2});
    vecs.push_back('{2'd0, 13'h0FF, 16'd2,   1,  1'b1, 16'd0});
    vecs.push_back('{2'd3, 13'h000, 16'd0,   50, 1'b0, 16'd0});
    vecs.push_back('{2'd1, 13'h010, 16'd0,   1,  1'b0, 16'd0});
    vecs.push_back('{2'd2, 13'h010, 16'd0,   1,  1'b0, 16'd0});
    vecs.push_back('{2'd0, 13'h010, 16'd0,   1,  1'b0, 16'd0});
    vecs.push_back('{2'd0, 13'h100, 16'd256, 1,  1'b0, 16'd256});
    vecs.push_back('{2'd0, 13'h001, 16'd256, 1,  1'b1, 16'd0});

    repeat (3) @(posedge clk);
    #1;
    chk("reset.cmd_ready", 64'(cmd_ready), 64'd1);
    chk("reset.tpu_mode", 64'(core_bus.tpu_mode), 64'd0);
    chk("reset.rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset.dma_len", 64'(core_bus.dma_len), 64'd0);
    chk("reset.instr_valid", 64'(core_bus.instr_valid), 64'd0);
    rst_req = 1'b0;
    repeat (2) @(posedge clk);

    foreach (vecs[k]) begin
      string tag;
      tag = $sformatf("vec%0d", k);
      pat = 0;
      comp_delay = vecs[k].cdelay;
      start_cmd(vecs[k].op, vecs[k].addr, vecs[k].len);
      wait_rsp(tag);
      model(vecs[k].op, vecs[k].addr, vecs[k].len);
      chk({tag, ".table_err"}, 64'(rsp_err_got), 64'(vecs[k].err));
      chk({tag, ".table_beats"}, 64'(rsp_beats_got), 64'(vecs[k].beats));
      compare(tag);
      if (vecs[k].len == 16'd0 && vecs[k].op != 2'd3)
        chk({tag, ".zero_len_latency_le2"}, 64'((rsp_cyc - acc_cyc) <= 2), 64'd1);
    end

    for (int r = 0; r < 40; r++) begin
      logic [1:0] op;
      logic [12:0] addr;
      logic [15:0] len;
      string tag;
      tag = $sformatf("rnd%0d", r);
      pat = 1;
      comp_delay = $urandom_range(30, 1);
      op = 2'($urandom_range(3, 0));
      addr = 13'($urandom);
      if ($urandom_range(1, 0) == 1) addr[7:0] = 8'($urandom_range(255, 248));
      len = 16'($urandom_range(6, 0));
      start_cmd(op, addr, len);
      wait_rsp(tag);
      model(op, addr, len);
      compare(tag);
    end

    // READ with the core never presenting data: driver must time out in XFER_R.
    pat = 2;
    dout_stuck = 1'b1;
    start_cmd(2'd2, 13'h040, 16'd3);
    wait_rsp("timeout");
    chk("timeout.err", 64'(rsp_err_got), 64'd1);
    chk("timeout.beats", 64'(rsp_beats_got), 64'd0);
    chk("timeout.latency_in_range",
        64'((rsp_cyc - acc_cyc) >= TB_TIMEOUT && (rsp_cyc - acc_cyc) <= TB_TIMEOUT + 5), 64'd1);
    chk("timeout.mode_after_busy", 64'(mode_bad), 64'd0);
    @(posedge clk);
    rst_req = 1'b1;
    repeat (2) @(posedge clk);
    dout_stuck = 1'b0;
    rst_req = 1'b0;
    repeat (2) @(posedge clk);

    // Reset while a WRITE is stalled in XFER_W with din_valid high.
    core_stall = 1'b1;
    start_cmd(2'd1, 13'h155, 16'd3);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #3;
      if (core_bus.din_valid) break;
    end
    chk("midreset.stalled_din_valid", 64'(core_bus.din_valid), 64'd1);
    rst_req = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("midreset.tpu_mode", 64'(core_bus.tpu_mode), 64'd0);
    chk("midreset.base_addr", 64'(core_bus.base_addr), 64'd0);
    chk("midreset.dma_len", 64'(core_bus.dma_len), 64'd0);
    chk("midreset.din_valid", 64'(core_bus.din_valid), 64'd0);
    chk("midreset.wdata_ready", 64'(wdata_ready), 64'd0);
    chk("midreset.rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midreset.rsp_err", 64'(rsp_err), 64'd0);
    chk("midreset.rsp_beats", 64'(rsp_beats), 64'd0);
    chk("midreset.instr_valid", 64'(core_bus.instr_valid), 64'd0);
    chk("midreset.instr_addr", 64'(core_bus.instr_addr), 64'd0);
    chk("midreset.cmd_ready", 64'(cmd_ready), 64'd1);
    wq.delete();
    core_stall = 1'b0;
    rst_req = 1'b0;
    repeat (6) @(posedge clk);
    chk("midreset.no_response", 64'(rsp_got), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
